// File: rtl/host_rd_arbiter_pkg.sv
// host_rd_arbiter_pkg
//   Shared types and helpers for the host read-channel arbiter.
//   ar_req_t  : one registered AR request {addr, len, size, id}; addr is sized
//               for the widest supported host address (ADDR_W <= 64), and id
//               for the largest supported master count (8).
//   rr_pick   : round-robin search over a request vector, starting at ptr.
//   cnt_width : bit width needed to hold 0..max_val inclusive.
package host_rd_arbiter_pkg;

  localparam int unsigned ARB_MAX_MASTERS = 8;
  localparam int unsigned ARB_IDX_W       = 3;
  localparam int unsigned ARB_ADDR_MAX_W  = 64;

  typedef struct packed {
    logic [ARB_ADDR_MAX_W-1:0] addr;
    logic [7:0]                len;
    logic [2:0]                size;
    logic [ARB_IDX_W-1:0]      id;
  } ar_req_t;

  typedef struct packed {
    logic                 found;
    logic [ARB_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

  // ptr must be < num; candidates wrap at num rather than at ARB_MAX_MASTERS.
  function automatic rr_pick_t rr_pick(input logic [ARB_MAX_MASTERS-1:0] req_vec,
                                       input logic [ARB_IDX_W-1:0]       ptr,
                                       input logic [ARB_IDX_W:0]         num);
    rr_pick_t             res;
    logic [ARB_IDX_W:0]   cand;
    res = '0;
    for (int unsigned k = 0; k < ARB_MAX_MASTERS; k++) begin
      cand = {1'b0, ptr} + (ARB_IDX_W + 1)'(k);
      if (cand >= num) cand = cand - num;
      if ((k < 32'(num)) && !res.found && req_vec[cand[ARB_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[ARB_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/host_rd_outstanding_cnt.sv
// host_rd_outstanding_cnt
//   Per-master in-flight burst counter, range 0..MAX_OUTSTANDING.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : burst granted to this master
//   dec      : last beat of a burst for this master accepted
//   count    : current in-flight bursts
//   full     : count == MAX_OUTSTANDING
//   An increment at full and a decrement at zero are both dropped, so a
//   stray rlast (e.g. a response to a burst issued before reset) cannot wrap.
module host_rd_outstanding_cnt
  import host_rd_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic inc_ok;
  logic dec_ok;

  always_comb begin
    full   = (count == CNT_W'(MAX_OUTSTANDING));
    inc_ok = inc && !full;
    dec_ok = dec && (count != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc_ok && !dec_ok) begin
      count <= count + CNT_W'(1);
    end else if (dec_ok && !inc_ok) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/host_rd_arbiter.sv
// host_rd_arbiter
//   Shares one host AXI-MM read channel (AR/R) between NUM_MASTERS readers.
//   AR: round-robin over masters below their outstanding limit, one-entry
//   output register, m_arid = master index. R: routed by m_rid, zero latency.
//   Ports:
//     bcd_clk, bcd_reset        clock, asynchronous active-high reset
//     s_ar*                     per-master request (flattened vectors)
//     s_r*                      per-master rvalid/rready, shared data/resp/last
//     m_ar*, m_r*               host read channel
//     err_bad_rid               sticky: beat seen with m_rid >= NUM_MASTERS
//     perf_grants, perf_stalls  per-master 32-bit saturating counters
//   Build option: define HOST_RD_ARB_PERF_EN to implement the perf counters;
//   otherwise they are tied to zero.
module host_rd_arbiter
  import host_rd_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned DATA_W          = 512,
  parameter int unsigned ID_W            = 3,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                      bcd_clk,
  input  logic                      bcd_reset,
  input  logic [NUM_MASTERS-1:0]    s_arvalid,
  output logic [NUM_MASTERS-1:0]    s_arready,
  input  logic [NUM_MASTERS*ADDR_W-1:0] s_araddr,
  input  logic [NUM_MASTERS*8-1:0]  s_arlen,
  input  logic [NUM_MASTERS*3-1:0]  s_arsize,
  output logic [NUM_MASTERS-1:0]    s_rvalid,
  input  logic [NUM_MASTERS-1:0]    s_rready,
  output logic [DATA_W-1:0]         s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rlast,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [7:0]                m_arlen,
  output logic [2:0]                m_arsize,
  output logic [ID_W-1:0]           m_arid,
  input  logic                      m_rvalid,
  output logic                      m_rready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic [ID_W-1:0]           m_rid,
  input  logic                      m_rlast,
  output logic                      err_bad_rid,
  output logic [NUM_MASTERS*32-1:0] perf_grants,
  output logic [NUM_MASTERS*32-1:0] perf_stalls
);

  localparam int unsigned CNT_W = cnt_width(MAX_OUTSTANDING);

  ar_req_t                    ar_q;
  ar_req_t                    sel_req;
  logic                       ar_valid_q;
  logic [ARB_IDX_W-1:0]       rr_ptr;
  logic [ARB_IDX_W-1:0]       ptr_nxt;
  logic [NUM_MASTERS-1:0]     full;
  logic [NUM_MASTERS-1:0]     eligible;
  logic [ARB_MAX_MASTERS-1:0] elig_pad;
  rr_pick_t                   pick;
  logic                       grant;
  logic                       rid_ok;
  logic [NUM_MASTERS-1:0]     rlast_dec;

  // ---------------- AR arbitration ----------------
  always_comb begin
    eligible = s_arvalid & ~full;
    elig_pad = '0;
    elig_pad[NUM_MASTERS-1:0] = eligible;
    pick = rr_pick(elig_pad, rr_ptr, (ARB_IDX_W + 1)'(NUM_MASTERS));
    // Register free now, or draining this cycle: one grant per clock.
    grant = pick.found && (!ar_valid_q || m_arready) && !bcd_reset;

    s_arready = '0;
    sel_req   = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (pick.idx == ARB_IDX_W'(i)) begin
        s_arready[i] = grant;
        sel_req.addr = ARB_ADDR_MAX_W'(s_araddr[i*ADDR_W +: ADDR_W]);
        sel_req.len  = s_arlen[i*8 +: 8];
        sel_req.size = s_arsize[i*3 +: 3];
      end
    end
    sel_req.id = pick.idx;

    if (32'(pick.idx) + 32'd1 >= NUM_MASTERS) ptr_nxt = '0;
    else                                     ptr_nxt = pick.idx + ARB_IDX_W'(1);
  end

  always_ff @(posedge bcd_clk or posedge bcd_reset) begin
    if (bcd_reset) begin
      ar_q       <= '0;
      ar_valid_q <= 1'b0;
      rr_ptr     <= '0;
    end else if (grant) begin
      ar_q       <= sel_req;
      ar_valid_q <= 1'b1;
      rr_ptr     <= ptr_nxt;
    end else if (m_arready) begin
      ar_valid_q <= 1'b0;
    end
  end

  always_comb begin
    m_arvalid = ar_valid_q;
    m_araddr  = ar_q.addr[ADDR_W-1:0];
    m_arlen   = ar_q.len;
    m_arsize  = ar_q.size;
    m_arid    = ID_W'(ar_q.id);
  end

  // ---------------- R routing ----------------
  always_comb begin
    rid_ok    = (32'(m_rid) < NUM_MASTERS);
    s_rvalid  = '0;
    m_rready  = 1'b1;  // unknown IDs are sunk so the host never stalls on them
    rlast_dec = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (m_rid == ID_W'(i)) begin
        s_rvalid[i] = m_rvalid;
        m_rready    = s_rready[i];
      end
    end
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      rlast_dec[i] = m_rvalid && m_rready && m_rlast && (m_rid == ID_W'(i));
    end
    s_rdata = m_rdata;
    s_rresp = m_rresp;
    s_rlast = m_rlast;
  end

  always_ff @(posedge bcd_clk or posedge bcd_reset) begin
    if (bcd_reset)                err_bad_rid <= 1'b0;
    else if (m_rvalid && !rid_ok) err_bad_rid <= 1'b1;
  end

  // ---------------- Outstanding counters ----------------
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_cnt
    logic [CNT_W-1:0] count;
    host_rd_outstanding_cnt #(
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CNT_W           (CNT_W)
    ) u_cnt (
      .clk   (bcd_clk),
      .rst   (bcd_reset),
      .inc   (s_arready[g]),
      .dec   (rlast_dec[g]),
      .count (count),
      .full  (full[g])
    );
  end

  // ---------------- Performance counters ----------------
`ifdef HOST_RD_ARB_PERF_EN
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_perf
    logic [31:0] grant_cnt;
    logic [31:0] stall_cnt;
    always_ff @(posedge bcd_clk or posedge bcd_reset) begin
      if (bcd_reset) begin
        grant_cnt <= '0;
        stall_cnt <= '0;
      end else begin
        if (s_arready[g] && (grant_cnt != '1))            grant_cnt <= grant_cnt + 32'd1;
        if (s_arvalid[g] && full[g] && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      end
    end
    assign perf_grants[g*32 +: 32] = grant_cnt;
    assign perf_stalls[g*32 +: 32] = stall_cnt;
  end
`else
  assign perf_grants = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_host_rd_arbiter.sv
// tb_host_rd_arbiter
//   Directed bench for host_rd_arbiter with NUM_MASTERS=2, MAX_OUTSTANDING=2,
//   ID_W=3 and narrow address/data. Inputs change 1 ns after the rising edge;
//   outputs are checked 1-2 ns after the edge.
module tb_host_rd_arbiter;

  localparam int unsigned NM   = 2;
  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned IW   = 3;
  localparam int unsigned MAXO = 2;

  logic              bcd_clk = 1'b0;
  logic              bcd_reset;
  logic [NM-1:0]     s_arvalid;
  logic [NM-1:0]     s_arready;
  logic [NM*AW-1:0]  s_araddr;
  logic [NM*8-1:0]   s_arlen;
  logic [NM*3-1:0]   s_arsize;
  logic [NM-1:0]     s_rvalid;
  logic [NM-1:0]     s_rready;
  logic [DW-1:0]     s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rlast;
  logic              m_arvalid;
  logic              m_arready;
  logic [AW-1:0]     m_araddr;
  logic [7:0]        m_arlen;
  logic [2:0]        m_arsize;
  logic [IW-1:0]     m_arid;
  logic              m_rvalid;
  logic              m_rready;
  logic [DW-1:0]     m_rdata;
  logic [1:0]        m_rresp;
  logic [IW-1:0]     m_rid;
  logic              m_rlast;
  logic              err_bad_rid;
  logic [NM*32-1:0]  perf_grants;
  logic [NM*32-1:0]  perf_stalls;

  int checks = 0;
  int errors = 0;

  always #5 bcd_clk = ~bcd_clk;

  host_rd_arbiter #(
    .NUM_MASTERS     (NM),
    .ADDR_W          (AW),
    .DATA_W          (DW),
    .ID_W            (IW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .bcd_clk     (bcd_clk),
    .bcd_reset   (bcd_reset),
    .s_arvalid   (s_arvalid),
    .s_arready   (s_arready),
    .s_araddr    (s_araddr),
    .s_arlen     (s_arlen),
    .s_arsize    (s_arsize),
    .s_rvalid    (s_rvalid),
    .s_rready    (s_rready),
    .s_rdata     (s_rdata),
    .s_rresp     (s_rresp),
    .s_rlast     (s_rlast),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_araddr    (m_araddr),
    .m_arlen     (m_arlen),
    .m_arsize    (m_arsize),
    .m_arid      (m_arid),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rid       (m_rid),
    .m_rlast     (m_rlast),
    .err_bad_rid (err_bad_rid),
    .perf_grants (perf_grants),
    .perf_stalls (perf_stalls)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge bcd_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] exp_rdy [4];
  logic [2:0] exp_id  [4];
  int         grants;

  initial begin
    exp_rdy = '{2'b10, 2'b01, 2'b10, 2'b00};
    exp_id  = '{3'd0, 3'd1, 3'd0, 3'd1};

    bcd_reset = 1'b1;
    s_arvalid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
    s_rready  = 2'b11; m_arready = 1'b1;
    m_rvalid  = 1'b0; m_rdata = '0; m_rresp = '0; m_rid = '0; m_rlast = 1'b0;
    #3;
    check("rst_arvalid", 64'(m_arvalid), 64'd0);
    check("rst_arready", 64'(s_arready), 64'd0);
    check("rst_err",     64'(err_bad_rid), 64'd0);
    step(); step();
    bcd_reset = 1'b0;

    // Both masters requesting continuously: alternate 0,1,0,1 then limit.
    s_araddr  = {32'hB000_0000, 32'hA000_0000};
    s_arlen   = {8'h1F, 8'h0F};
    s_arsize  = {3'd5, 3'd6};
    s_arvalid = 2'b11;
    #1;
    check("t1_arready_first", 64'(s_arready), 64'b01);
    check("t1_arvalid_pre",   64'(m_arvalid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t1_arvalid_%0d", k), 64'(m_arvalid), 64'd1);
      check($sformatf("t1_arid_%0d", k),    64'(m_arid), 64'(exp_id[k]));
      check($sformatf("t1_arready_%0d", k), 64'(s_arready), 64'(exp_rdy[k]));
      if (k == 0) begin
        check("t1_addr0", 64'(m_araddr), 64'hA000_0000);
        check("t1_len0",  64'(m_arlen),  64'h0F);
        check("t1_size0", 64'(m_arsize), 64'd6);
      end
      if (k == 1) begin
        check("t1_addr1", 64'(m_araddr), 64'hB000_0000);
        check("t1_len1",  64'(m_arlen),  64'h1F);
        check("t1_size1", 64'(m_arsize), 64'd5);
      end
    end
    s_arvalid = 2'b00;
    step();
    check("t1_drain", 64'(m_arvalid), 64'd0);

    // Interleaved R beats, with backpressure from master 1 on the first.
    s_rready = 2'b01;
    m_rvalid = 1'b1; m_rid = 3'd1; m_rlast = 1'b0; m_rdata = 32'hDEAD_0001; m_rresp = 2'b00;
    #1;
    check("r1_svalid",  64'(s_rvalid), 64'b10);
    check("r1_mready",  64'(m_rready), 64'd0);
    check("r1_data",    64'(s_rdata),  64'hDEAD_0001);
    s_rready = 2'b11;
    #1;
    check("r1_mready_go", 64'(m_rready), 64'd1);
    step();
    m_rid = 3'd0; m_rlast = 1'b1; m_rdata = 32'hDEAD_0002; m_rresp = 2'b10;
    #1;
    check("r2_svalid", 64'(s_rvalid), 64'b01);
    check("r2_rlast",  64'(s_rlast),  64'd1);
    check("r2_rresp",  64'(s_rresp),  64'd2);
    check("r2_mready", 64'(m_rready), 64'd1);
    step();
    m_rid = 3'd1; m_rlast = 1'b1;
    #1;
    check("r3_svalid", 64'(s_rvalid), 64'b10);
    step();
    m_rid = 3'd0; step();
    m_rid = 3'd1; step();
    m_rvalid = 1'b0; m_rlast = 1'b0;

    // Master 0 alone, no responses: exactly MAXO grants, then released by one rlast.
    s_arvalid = 2'b01;
    grants = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (s_arready[0]) grants++;
      step();
    end
    check("t2_grant_count", 64'(grants), 64'd2);
    check("t2_blocked", 64'(s_arready), 64'd0);
    m_rvalid = 1'b1; m_rid = 3'd0; m_rlast = 1'b1;
    #1;
    check("t2_blocked_on_dec", 64'(s_arready), 64'd0);
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    check("t2_third_grant", 64'(s_arready), 64'b01);
    step();
    check("t2_third_arid", 64'(m_arid), 64'd0);
    check("t2_full_again", 64'(s_arready), 64'd0);
    s_arvalid = 2'b00;
    step();
    check("t2_drain", 64'(m_arvalid), 64'd0);

    // Host backpressure: loaded request holds steady.
    m_arready = 1'b0;
    s_arvalid = 2'b10;
    s_araddr[63:32] = 32'h1111_0000;
    s_arlen[15:8]   = 8'h07;
    #1;
    check("t3_load", 64'(s_arready), 64'b10);
    step();
    s_araddr[63:32] = 32'h2222_0000;
    s_arlen[15:8]   = 8'h03;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("t3_valid_%0d", k), 64'(m_arvalid), 64'd1);
      check($sformatf("t3_addr_%0d", k),  64'(m_araddr),  64'h1111_0000);
      check($sformatf("t3_len_%0d", k),   64'(m_arlen),   64'h07);
      check($sformatf("t3_id_%0d", k),    64'(m_arid),    64'd1);
      check($sformatf("t3_nordy_%0d", k), 64'(s_arready), 64'd0);
      step();
    end
    s_arvalid = 2'b00;
    m_arready = 1'b1;
    step();
    check("t3_drain", 64'(m_arvalid), 64'd0);

    // Out-of-range response ID.
    s_rready = 2'b00;
    m_rvalid = 1'b1; m_rid = 3'd5; m_rlast = 1'b1;
    #1;
    check("t5_mready", 64'(m_rready), 64'd1);
    check("t5_svalid", 64'(s_rvalid), 64'd0);
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0; s_rready = 2'b11;
    #1;
    check("t5_err_set", 64'(err_bad_rid), 64'd1);
    step(); step();
    check("t5_err_sticky", 64'(err_bad_rid), 64'd1);

    // Reset with 3 bursts outstanding (m0:2, m1:1), pointer at 1, request held.
    m_rvalid = 1'b1; m_rid = 3'd0; m_rlast = 1'b1;
    step();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    m_arready = 1'b0;
    s_arvalid = 2'b01;
    #1;
    check("t6_pre_grant", 64'(s_arready), 64'b01);
    step();
    s_arvalid = 2'b00;
    #1;
    check("t6_pre_arvalid", 64'(m_arvalid), 64'd1);
    bcd_reset = 1'b1;
    #1;
    check("t6_async_drop", 64'(m_arvalid), 64'd0);
    check("t6_rst_arready", 64'(s_arready), 64'd0);
    check("t6_err_clear", 64'(err_bad_rid), 64'd0);
    step();
    bcd_reset = 1'b0;
    m_arready = 1'b1;
    s_arvalid = 2'b11;
    #1;
    check("t6_first_to_m0", 64'(s_arready), 64'b01);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("t6_arid_%0d", k),    64'(m_arid), 64'(exp_id[k]));
      check($sformatf("t6_arready_%0d", k), 64'(s_arready), 64'(exp_rdy[k]));
    end
`ifdef HOST_RD_ARB_PERF_EN
    check("perf_grants", 64'(perf_grants), {32'd2, 32'd2});
`else
    check("perf_grants_off", 64'(perf_grants), 64'd0);
    check("perf_stalls_off", 64'(perf_stalls), 64'd0);
`endif
    s_arvalid = 2'b00;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_rd_arbiter.md
Name: host_rd_arbiter

Overview:
- Shares the single host AXI-MM read channel (AR/R) between NUM_MASTERS independent read masters, e.g. several Fletcher readers in the bcd domain.
- Round-robin arbitration on AR; each granted request is stamped with m_arid equal to the master index.
- R beats are routed back to the owning master by m_rid.
- A per-master outstanding-burst limit prevents one master from monopolising host tags.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- ADDR_W, 64, address width.
- DATA_W, 512, read data width.
- ID_W, 3, m_arid/m_rid width; must satisfy 2**ID_W >= NUM_MASTERS.
- MAX_OUTSTANDING, 16, maximum in-flight bursts per master.

Ports:
- bcd_clk  in  1  clock
- bcd_reset  in  1  asynchronous active-high reset
- s_arvalid  in  NUM_MASTERS  per-master request valid
- s_arready  out  NUM_MASTERS  per-master request accept
- s_araddr  in  NUM_MASTERS*ADDR_W  flattened addresses; master i at [i*ADDR_W +: ADDR_W]
- s_arlen  in  NUM_MASTERS*8  flattened burst lengths
- s_arsize  in  NUM_MASTERS*3  flattened burst sizes
- s_rvalid  out  NUM_MASTERS  per-master read beat valid
- s_rready  in  NUM_MASTERS  per-master read beat ready
- s_rdata  out  DATA_W  shared read data (broadcast)
- s_rresp  out  2  shared read response
- s_rlast  out  1  shared last beat
- m_arvalid  out  1  host request valid
- m_arready  in  1  host request ready
- m_araddr  out  ADDR_W  host address
- m_arlen  out  8  host burst length
- m_arsize  out  3  host burst size
- m_arid  out  ID_W  granted master index
- m_rvalid  in  1  host beat valid
- m_rready  out  1  host beat ready
- m_rdata  in  DATA_W  host beat data
- m_rresp  in  2  host beat response
- m_rid  in  ID_W  host beat ID
- m_rlast  in  1  host last beat
- err_bad_rid  out  1  sticky flag: beat received with m_rid >= NUM_MASTERS
- perf_grants  out  NUM_MASTERS*32  per-master grant counters
- perf_stalls  out  NUM_MASTERS*32  per-master limit-stall cycle counters

Behaviour:
- Reset (async assert, released synchronously to bcd_clk):
  - m_arvalid=0, s_arready=0, RR pointer=0.
  - All outstanding counters=0, err_bad_rid=0, perf counters=0.
- AR output register:
  - One entry, holding {addr, len, size, id}.
  - A grant is allowed when the register is empty, or when m_arvalid && m_arready in the same cycle (full throughput, one grant per cycle).
  - Latency from s_arvalid to m_arvalid is 1 cycle.
  - Register contents stay stable while m_arvalid && !m_arready.
- Arbitration:
  - Eligible(i) = s_arvalid[i] && outstanding[i] < MAX_OUTSTANDING.
  - Round-robin search starts at RR pointer; the first eligible master wins.
  - s_arready[i] is combinational and high only for the winner in the cycle the grant is taken.
  - On a grant, RR pointer = winner+1, wrapping at NUM_MASTERS.
  - No eligible master: no grant, pointer unchanged.
- Outstanding counters:
  - Width is clog2(MAX_OUTSTANDING+1).
  - +1 on grant to i.
  - -1 on m_rvalid && m_rready && m_rlast with m_rid==i.
  - Increment and decrement in the same cycle leave the counter unchanged.
  - A counter never exceeds MAX_OUTSTANDING and never underflows; an unexpected rlast at count 0 is ignored.
- R path (combinational, zero latency):
  - s_rvalid[i] = m_rvalid && (m_rid==i).
  - m_rready = s_rready[m_rid].
  - s_rdata/s_rresp/s_rlast pass through unchanged.
  - m_rid >= NUM_MASTERS: m_rready=1 (beat dropped), no s_rvalid asserted, err_bad_rid set until reset.
- Reset mid-burst: all state clears immediately. In-flight host responses arriving after reset are routed normally, but counters do not decrement below 0.
- Out-of-order responses between masters are allowed. Per-master ordering relies on the host preserving same-ID order.

Optional Feature:
- Macro: HOST_RD_ARB_PERF_EN.
- Defined:
  - perf_grants[i] increments on each grant to master i.
  - perf_stalls[i] increments each cycle s_arvalid[i] is high while outstanding[i]==MAX_OUTSTANDING.
  - Counters saturate at 2**32-1.
- Not defined: perf_grants and perf_stalls are tied to 0 and no counter logic is synthesised.

Decomposition:
- Package host_rd_arbiter_pkg holds:
  - the ar_req_t struct {addr, len, size, id};
  - the function rr_pick(req_vec, ptr) returning the winning index and a found bit;
  - the localparam CNT_W derivation helper.
- Sub-module host_rd_outstanding_cnt: one saturating up/down counter with a full flag, instantiated per master.

Test Plan:
- Masters 0 and 1 assert s_arvalid continuously, host m_arready=1 -> m_arid sequence 0,1,0,1…, one grant per cycle, first m_arvalid one cycle after the first s_arvalid.
- MAX_OUTSTANDING=2, master 0 only, no R returned -> exactly 2 grants, then s_arready[0]=0. One rlast beat with m_rid=0 -> third grant on the next cycle.
- m_arready held 0 for 5 cycles with a request loaded -> m_araddr/m_arlen/m_arid stable, no further s_arready.
- Interleaved beats: m_rid=1 (rlast=0), m_rid=0 (rlast=1), m_rid=1 (rlast=1) -> s_rvalid pulses 2,1,2 (one-hot bit vectors). s_rready[1]=0 on the first beat -> m_rready=0.
- m_rvalid with m_rid=5, NUM_MASTERS=2 -> m_rready=1, s_rvalid=0, err_bad_rid=1 persisting until bcd_reset.
- Assert bcd_reset while 3 bursts are outstanding and m_arvalid=1 -> m_arvalid drops without waiting for a clock edge, counters read 0, first post-reset grant goes to master 0.
